// File: rtl/cache_pkg.sv
// Shared types and geometry for the 2-way set-associative write-through data cache.
package cache_pkg;

  localparam int INDEX_W = 6;
  localparam int TAG_W   = 11;
  localparam int WAYS    = 2;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } entry_t;

endpackage

// File: rtl/cache_if.sv
// CPU memory-stage and SRAM-controller signals of the data cache, bundled together.
interface cache_if;

  logic        rd_en;
  logic        wr_en;
  logic [31:0] ALU_Res;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        ready;

  logic        sram_rd_en;
  logic        sram_wr_en;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ready;

  // Master is the environment (CPU stage plus SRAM controller); slave is the cache.
  modport master (
    output rd_en, wr_en, ALU_Res, writeData, sram_rdata, sram_ready,
    input  readData, ready, sram_rd_en, sram_wr_en, sram_addr, sram_wdata
  );

  modport slave (
    input  rd_en, wr_en, ALU_Res, writeData, sram_rdata, sram_ready,
    output readData, ready, sram_rd_en, sram_wr_en, sram_addr, sram_wdata
  );

endinterface

// File: rtl/cache_set_store.sv
// Way/set storage: combinational read of both ways of one set, synchronous single-way
// write, and a synchronous clear of every valid bit on rst.
module cache_set_store
  import cache_pkg::*;
#(
  parameter int SETS = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output entry_t             rd_entry [WAYS],
  input  logic               wr_en,
  input  logic               wr_way,
  input  logic [INDEX_W-1:0] wr_index,
  input  entry_t             wr_entry
);

  logic [SETS-1:0]  valid_q [WAYS];
  logic [TAG_W-1:0] tag_q   [WAYS][SETS];
  logic [31:0]      data_q  [WAYS][SETS];

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      rd_entry[w].valid = valid_q[w][rd_index];
      rd_entry[w].tag   = tag_q[w][rd_index];
      rd_entry[w].data  = data_q[w][rd_index];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
    end else if (wr_en) begin
      valid_q[wr_way][wr_index] <= wr_entry.valid;
    end
  end

  // Tag and data payload carry no reset; only the valid bits decide a hit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_way][wr_index]  <= wr_entry.tag;
      data_q[wr_way][wr_index] <= wr_entry.data;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// 2-way LRU write-through, no-write-allocate data cache in front of an SRAM controller.
// Define CACHE_STATS_EN to add the hit_count / miss_count statistics outputs.
module cache_controller
  import cache_pkg::*;
#(
  parameter int          SETS      = 64,
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input logic    clk,
  input logic    rst,
  cache_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  state_t             state_q, state_d;
  logic [SETS-1:0]    lru_q, lru_d;
  logic [31:0]        addr;
  logic [14:0]        addr_unused;
  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  entry_t             rd_entry [WAYS];
  logic [WAYS-1:0]    way_hit;
  logic               tag_hit;
  logic               hit;
  logic               hit_way;
  logic               victim_way;
  logic               st_wr_en;
  logic               st_wr_way;
  entry_t             st_wr_entry;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

  assign addr        = bus.ALU_Res - BASE_ADDR;
  assign index       = addr[2 +: INDEX_W];
  assign tag         = addr[8 +: TAG_W];
  assign addr_unused = {addr[31:19], addr[1:0]};

  cache_set_store #(.SETS(SETS)) u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_index (index),
    .rd_entry (rd_entry),
    .wr_en    (st_wr_en),
    .wr_way   (st_wr_way),
    .wr_index (index),
    .wr_entry (st_wr_entry)
  );

  // Invalid ways fill first (way 0 before way 1); a full set evicts the LRU way.
  always_comb begin
    for (int w = 0; w < WAYS; w++) way_hit[w] = rd_entry[w].valid && (rd_entry[w].tag == tag);
    tag_hit    = |way_hit;
    hit        = bus.rd_en & tag_hit;
    hit_way    = way_hit[1];
    victim_way = !rd_entry[0].valid ? 1'b0 : (!rd_entry[1].valid ? 1'b1 : lru_q[index]);
  end

  always_comb begin
    state_d           = state_q;
    lru_d             = lru_q;
    st_wr_en          = 1'b0;
    st_wr_way         = victim_way;
    st_wr_entry.valid = 1'b1;
    st_wr_entry.tag   = tag;
    st_wr_entry.data  = bus.sram_rdata;
    bus.ready         = 1'b0;
    bus.readData      = '0;
    bus.sram_rd_en    = 1'b0;
    bus.sram_wr_en    = 1'b0;
    bus.sram_addr     = '0;
    bus.sram_wdata    = '0;
`ifdef CACHE_STATS_EN
    hit_count_d       = hit_count_q;
    miss_count_d      = miss_count_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.wr_en) begin
          state_d = WR;
        end else if (hit) begin
          bus.ready     = 1'b1;
          bus.readData  = rd_entry[hit_way].data;
          lru_d[index]  = ~hit_way;
`ifdef CACHE_STATS_EN
          hit_count_d   = hit_count_q + 32'd1;
`endif
        end else if (bus.rd_en) begin
          state_d = RD_MISS;
        end else begin
          bus.ready = 1'b1;
        end
      end
      RD_MISS: begin
        bus.sram_rd_en = 1'b1;
        bus.sram_addr  = bus.ALU_Res;
        if (bus.sram_ready) begin
          bus.ready    = 1'b1;
          bus.readData = bus.sram_rdata;
          st_wr_en     = 1'b1;
          lru_d[index] = ~victim_way;
          state_d      = IDLE;
`ifdef CACHE_STATS_EN
          miss_count_d = miss_count_q + 32'd1;
`endif
        end
      end
      WR: begin
        bus.sram_wr_en = 1'b1;
        bus.sram_addr  = bus.ALU_Res;
        bus.sram_wdata = bus.writeData;
        if (bus.sram_ready) begin
          bus.ready = 1'b1;
          state_d   = IDLE;
          if (tag_hit) begin
            st_wr_en         = 1'b1;
            st_wr_way        = hit_way;
            st_wr_entry.data = bus.writeData;
            lru_d[index]     = ~hit_way;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset overrides everything, even mid-transaction: no fills, no SRAM requests.
    if (rst) begin
      st_wr_en       = 1'b0;
      bus.ready      = ~(bus.rd_en | bus.wr_en);
      bus.readData   = '0;
      bus.sram_rd_en = 1'b0;
      bus.sram_wr_en = 1'b0;
      bus.sram_addr  = '0;
      bus.sram_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lru_q        <= '0;
`ifdef CACHE_STATS_EN
      hit_count_q  <= '0;
      miss_count_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lru_q        <= lru_d;
`ifdef CACHE_STATS_EN
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
`endif
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed scenarios plus randomized traffic
// against a recency-ordered cache model and an SRAM model that answers 5 cycles in.
module tb_cache_controller;

  localparam int          SRAM_LAT = 5;
  localparam logic [31:0] BASE     = 32'd1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_if cif ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  cache_controller #(.SETS(64), .BASE_ADDR(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (cif)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  typedef struct {
    int          idx;
    int          tag;
    logic [31:0] data;
  } ment_t;

  int          checks = 0;
  int          errors = 0;
  int          model_hits = 0;
  int          model_misses = 0;
  ment_t       cacheq[$];
  logic [31:0] sram_mem [logic [29:0]];
  bit          last_hit;
  logic [31:0] last_data;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sram_read(input logic [31:0] a);
    if (!sram_mem.exists(a[31:2])) sram_mem[a[31:2]] = {a[15:0], ~a[15:0]};
    return sram_mem[a[31:2]];
  endfunction

  function automatic void split(input logic [31:0] a, output int idx, output int tag);
    logic [31:0] off;
    off = a - BASE;
    idx = int'((off >> 2) % 64);
    tag = int'((off >> 8) % 2048);
  endfunction

  function automatic int find_entry(input int idx, input int tag);
    for (int i = 0; i < cacheq.size(); i++)
      if (cacheq[i].idx == idx && cacheq[i].tag == tag) return i;
    return -1;
  endfunction

  // Front of the queue is most recently used; a set holds at most two lines.
  function automatic void touch(input int i);
    ment_t e;
    e = cacheq[i];
    cacheq.delete(i);
    cacheq.push_front(e);
  endfunction

  function automatic void insert(input int idx, input int tag, input logic [31:0] d);
    ment_t e;
    int    n;
    e.idx = idx; e.tag = tag; e.data = d;
    cacheq.push_front(e);
    n = 0;
    for (int i = 0; i < cacheq.size(); i++) if (cacheq[i].idx == idx) n++;
    if (n > 2) begin
      for (int i = cacheq.size() - 1; i >= 0; i--) begin
        if (cacheq[i].idx == idx) begin
          cacheq.delete(i);
          break;
        end
      end
    end
  endfunction

  // Drives one request from a negedge, plays the SRAM controller, returns completion info.
  task automatic applyStimulus(input bit is_wr, input logic [31:0] a, input logic [31:0] wd,
                               output bit was_hit, output logic [31:0] rdata, output int lat);
    int en_cnt = 0;
    bit done = 0;
    int cyc = 0;
    cif.rd_en = !is_wr; cif.wr_en = is_wr; cif.ALU_Res = a; cif.writeData = wd;
    cif.sram_ready = 1'b0; cif.sram_rdata = $urandom;
    was_hit = 0; rdata = '0; lat = -1;
    while (!done && cyc < 20) begin
      #1;
      if (cif.sram_rd_en || cif.sram_wr_en) begin
        en_cnt++;
        if (en_cnt == 1) begin
          checkOutput("sram_addr", cif.sram_addr, a);
          checkOutput("sram_wdata", cif.sram_wdata, is_wr ? wd : 32'h0);
          checkOutput("sram_rd_en", {31'h0, cif.sram_rd_en}, {31'h0, !is_wr});
          checkOutput("sram_wr_en", {31'h0, cif.sram_wr_en}, {31'h0, is_wr});
        end
        if (en_cnt == SRAM_LAT) begin
          cif.sram_ready = 1'b1;
          if (is_wr) sram_mem[cif.sram_addr[31:2]] = cif.sram_wdata;
          else cif.sram_rdata = sram_read(a);
        end
        #1;
      end
      if (cif.ready) begin
        done = 1; lat = cyc; rdata = cif.readData;
        was_hit = (cyc == 0) && !is_wr;
      end else begin
        checkOutput("readData_not_valid", cif.readData, 32'h0);
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    checkOutput("completed", {31'h0, done}, 32'h1);
    cif.rd_en = 1'b0; cif.wr_en = 1'b0; cif.sram_ready = 1'b0;
    #1;
    checkOutput("sram_en_drop", {30'h0, cif.sram_rd_en, cif.sram_wr_en}, 32'h0);
    checkOutput("ready_when_idle", {31'h0, cif.ready}, 32'h1);
  endtask

  task automatic doRead(input logic [31:0] a);
    int          idx, tag, i, lat;
    bit          exp_hit;
    logic [31:0] exp_data;
    split(a, idx, tag);
    i = find_entry(idx, tag);
    exp_hit  = (i >= 0);
    exp_data = exp_hit ? cacheq[i].data : sram_read(a);
    applyStimulus(1'b0, a, 32'h0, last_hit, last_data, lat);
    checkOutput("read_hit", {31'h0, last_hit}, {31'h0, exp_hit});
    checkOutput("read_data", last_data, exp_data);
    checkOutput("read_latency", lat, exp_hit ? 0 : SRAM_LAT);
    if (exp_hit) begin
      touch(i);
      model_hits++;
    end else begin
      insert(idx, tag, exp_data);
      model_misses++;
    end
  endtask

  task automatic doWrite(input logic [31:0] a, input logic [31:0] wd);
    int          idx, tag, i, lat;
    bit          h;
    logic [31:0] d;
    applyStimulus(1'b1, a, wd, h, d, lat);
    checkOutput("write_latency", lat, SRAM_LAT);
    split(a, idx, tag);
    i = find_entry(idx, tag);
    if (i >= 0) begin
      cacheq[i].data = wd;
      touch(i);
    end
  endtask

  task automatic doReset();
    rst = 1'b1; cif.rd_en = 1'b0; cif.wr_en = 1'b0; cif.sram_ready = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    checkOutput("rst_ready", {31'h0, cif.ready}, 32'h1);
    checkOutput("rst_sram_en", {30'h0, cif.sram_rd_en, cif.sram_wr_en}, 32'h0);
    checkOutput("rst_readData", cif.readData, 32'h0);
    cif.rd_en = 1'b1; cif.ALU_Res = 32'h400; #1;
    checkOutput("rst_ready_with_req", {31'h0, cif.ready}, 32'h0);
    checkOutput("rst_readData_with_req", cif.readData, 32'h0);
    cif.rd_en = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    cacheq.delete();
    model_hits = 0; model_misses = 0;
    #1;
    checkOutput("post_rst_ready", {31'h0, cif.ready}, 32'h1);
`ifdef CACHE_STATS_EN
    checkOutput("rst_hit_count", hit_count, 32'h0);
    checkOutput("rst_miss_count", miss_count, 32'h0);
`endif
  endtask

  initial begin
    logic [31:0] a;
    cif.rd_en = 1'b0; cif.wr_en = 1'b0; cif.ALU_Res = '0; cif.writeData = '0;
    cif.sram_rdata = '0; cif.sram_ready = 1'b0;
    sram_mem[30'(32'h400 >> 2)] = 32'hDEADBEEF;
    doReset();

    $display("[TB] cold read and repeat hit");
    doRead(32'h400);
    checkOutput("cold_miss", {31'h0, last_hit}, 32'h0);
    checkOutput("cold_data", last_data, 32'hDEADBEEF);
    doRead(32'h400);
    checkOutput("repeat_hit", {31'h0, last_hit}, 32'h1);

    $display("[TB] write without allocate");
    doWrite(32'h404, 32'h12345678);
    checkOutput("sram_got_write", sram_mem[30'(32'h404 >> 2)], 32'h12345678);
    doRead(32'h404);
    checkOutput("no_alloc_miss", {31'h0, last_hit}, 32'h0);

    $display("[TB] write hit updates cached line");
    doWrite(32'h400, 32'hCAFEF00D);
    checkOutput("sram_wr_hit", sram_mem[30'(32'h400 >> 2)], 32'hCAFEF00D);
    doRead(32'h400);
    checkOutput("wr_hit_then_hit", {31'h0, last_hit}, 32'h1);
    checkOutput("wr_hit_data", last_data, 32'hCAFEF00D);

    $display("[TB] LRU eviction in set 0");
    doReset();
    doRead(32'h400);
    doRead(32'h500);
    doRead(32'h400);
    checkOutput("lru_rehit", {31'h0, last_hit}, 32'h1);
    doRead(32'h600);
    checkOutput("lru_fill_miss", {31'h0, last_hit}, 32'h0);
`ifdef CACHE_STATS_EN
    checkOutput("stats_hit", hit_count, 32'd1);
    checkOutput("stats_miss", miss_count, 32'd3);
`endif
    doRead(32'h400);
    checkOutput("lru_kept", {31'h0, last_hit}, 32'h1);
    doRead(32'h500);
    checkOutput("lru_evicted", {31'h0, last_hit}, 32'h0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 150; n++) begin
      a = BASE + (32'($urandom_range(0, 3)) << 8) + (32'($urandom_range(0, 2)) << 2)
               + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 3) doWrite(a, $urandom);
      else doRead(a);
    end
`ifdef CACHE_STATS_EN
    checkOutput("stats_hit_total", hit_count, 32'(model_hits));
    checkOutput("stats_miss_total", miss_count, 32'(model_misses));
`endif

    $display("[TB] reset in the middle of a read miss");
    doRead(32'h400);
    doRead(32'h400);
    checkOutput("pre_abort_hit", {31'h0, last_hit}, 32'h1);
    cif.rd_en = 1'b1; cif.ALU_Res = 32'h700; cif.sram_ready = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    checkOutput("abort_miss_started", {31'h0, cif.sram_rd_en}, 32'h1);
    @(posedge clk); @(negedge clk);
    rst = 1'b1; #1;
    checkOutput("abort_sram_rd_in_rst", {31'h0, cif.sram_rd_en}, 32'h0);
    checkOutput("abort_ready_in_rst", {31'h0, cif.ready}, 32'h0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0; cif.rd_en = 1'b0;
    cacheq.delete();
    model_hits = 0; model_misses = 0;
    #1;
    checkOutput("abort_sram_rd_after", {31'h0, cif.sram_rd_en}, 32'h0);
    checkOutput("abort_idle_ready", {31'h0, cif.ready}, 32'h1);
    @(posedge clk); @(negedge clk);
    doRead(32'h400);
    checkOutput("abort_then_miss", {31'h0, last_hit}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
